// File: rtl/calc2_pkg.sv
// Shared calc2 port types: command and response codes, tag type and default data width.
package calc2_pkg;

  localparam int DATA_W = 32;

  typedef logic [1:0] tag_t;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE    = 2'd0,
    RESP_OK      = 2'd1,
    RESP_ERR     = 2'd2,
    RESP_TIMEOUT = 2'd3
  } resp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/calc2_tag_tracker.sv
// Outstanding-tag bookkeeping for one calc2 port: busy bitmap, per-tag watchdogs,
// lowest-free-tag and lowest-timed-out-tag encoders.
module calc2_tag_tracker
  import calc2_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       alloc_i,
  input  logic       free_i,
  input  tag_t       free_tag_i,
  output logic [3:0] busy_o,
  output logic       full_o,
  output tag_t       alloc_tag_o,
  output logic       to_pend_o,
  output tag_t       to_tag_o
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  logic [3:0]            busy_q, busy_d;
  logic [3:0][CNT_W-1:0] wd_q, wd_d;

  always_comb begin
    alloc_tag_o = '0;
    to_pend_o   = 1'b0;
    to_tag_o    = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_tag_o = tag_t'(i);
      end
      if (busy_q[i] && (wd_q[i] == TO_LIMIT)) begin
        to_pend_o = 1'b1;
        to_tag_o  = tag_t'(i);
      end
    end
  end

  // The watchdog loads 1 so the issue cycle itself counts toward TIMEOUT; the
  // registered result then appears exactly TIMEOUT cycles after issue.
  always_comb begin
    busy_d = busy_q;
    wd_d   = wd_q;
    for (int i = 0; i < 4; i++) begin
      if (alloc_i && (alloc_tag_o == tag_t'(i))) begin
        busy_d[i] = 1'b1;
        wd_d[i]   = CNT_W'(1);
      end else if (free_i && (free_tag_i == tag_t'(i))) begin
        busy_d[i] = 1'b0;
        wd_d[i]   = '0;
      end else if (busy_q[i] && (wd_q[i] != TO_LIMIT)) begin
        wd_d[i] = wd_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
      wd_q   <= '0;
    end else begin
      busy_q <= busy_d;
      wd_q   <= wd_d;
    end
  end

  assign busy_o = busy_q;
  assign full_o = &busy_q;

endmodule

// File: rtl/calc2_port_sequencer.sv
// Per-port calc2 front end: accepts host operations, issues the two-cycle tagged
// request, and reports matched responses or watchdog timeouts as result pulses.
module calc2_port_sequencer
  import calc2_pkg::*;
#(
  parameter int DATA_W  = calc2_pkg::DATA_W,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [3:0]        host_cmd,
  input  logic [DATA_W-1:0] host_op1,
  input  logic [DATA_W-1:0] host_op2,
  output logic [3:0]        req_cmd_out,
  output logic [DATA_W-1:0] req_data_out,
  output logic [1:0]        req_tag_out,
  input  logic [1:0]        resp_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        tag_in,
  output logic              res_valid,
  output logic [1:0]        res_resp,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_tag,
  output logic [3:0]        busy_tags,
  output logic              spurious_err
);

  seq_state_e        state_q, state_d;
  logic [3:0]        req_cmd_q, req_cmd_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  tag_t              req_tag_q, req_tag_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic              res_valid_q, res_valid_d;
  logic [1:0]        res_resp_q, res_resp_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  tag_t              res_tag_q, res_tag_d;
  logic              spurious_q, spurious_d;

  logic [3:0] busy;
  logic       full, accept, alloc, resp_hit, free, to_pend;
  tag_t       alloc_tag, free_tag, to_tag;

  calc2_tag_tracker #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_tracker (
    .clk_i      (c_clk),
    .reset_i    (reset),
    .alloc_i    (alloc),
    .free_i     (free),
    .free_tag_i (free_tag),
    .busy_o     (busy),
    .full_o     (full),
    .alloc_tag_o(alloc_tag),
    .to_pend_o  (to_pend),
    .to_tag_o   (to_tag)
  );

  always_comb begin
    host_ready = (state_q == ST_IDLE) && !full && !reset;
    accept     = host_valid && host_ready;
    alloc      = accept && (host_cmd != CMD_NOP);
    state_d    = state_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    req_tag_d  = '0;
    op2_d      = op2_q;
    case (state_q)
      ST_IDLE: begin
        if (alloc) begin
          req_cmd_d  = host_cmd;
          req_data_d = host_op1;
          req_tag_d  = alloc_tag;
          op2_d      = host_op2;
          state_d    = ST_OP2;
        end
      end
      ST_OP2: begin
        req_data_d = op2_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A real response always wins the single result slot; timeouts wait a cycle.
  always_comb begin
    resp_hit    = (resp_in != RESP_NONE) && busy[tag_in];
    spurious_d  = spurious_q || ((resp_in != RESP_NONE) && !busy[tag_in]);
    res_valid_d = 1'b0;
    res_resp_d  = '0;
    res_data_d  = '0;
    res_tag_d   = '0;
    free        = 1'b0;
    free_tag    = '0;
    if (resp_hit) begin
      res_valid_d = 1'b1;
      res_resp_d  = resp_in;
      res_data_d  = data_in;
      res_tag_d   = tag_in;
      free        = 1'b1;
      free_tag    = tag_in;
    end else if (to_pend) begin
      res_valid_d = 1'b1;
      res_resp_d  = RESP_TIMEOUT;
      res_tag_d   = to_tag;
      free        = 1'b1;
      free_tag    = to_tag;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_cmd_q   <= '0;
      req_data_q  <= '0;
      req_tag_q   <= '0;
      op2_q       <= '0;
      res_valid_q <= 1'b0;
      res_resp_q  <= '0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_cmd_q   <= req_cmd_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      op2_q       <= op2_d;
      res_valid_q <= res_valid_d;
      res_resp_q  <= res_resp_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      spurious_q  <= spurious_d;
    end
  end

  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign req_tag_out  = req_tag_q;
  assign res_valid    = res_valid_q;
  assign res_resp     = res_resp_q;
  assign res_data     = res_data_q;
  assign res_tag      = res_tag_q;
  assign busy_tags    = busy;
  assign spurious_err = spurious_q;

endmodule

// File: tb/tb_calc2_port_sequencer.sv
// Bench for calc2_port_sequencer: directed scenarios plus a randomized run
// checked against a tag/issue-time reference model.
module tb_calc2_port_sequencer;
  import calc2_pkg::*;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          c_clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_valid, host_ready;
  logic [3:0]    host_cmd;
  logic [DW-1:0] host_op1, host_op2;
  logic [3:0]    req_cmd_out;
  logic [DW-1:0] req_data_out;
  logic [1:0]    req_tag_out;
  logic [1:0]    resp_in;
  logic [DW-1:0] data_in;
  logic [1:0]    tag_in;
  logic          res_valid;
  logic [1:0]    res_resp;
  logic [DW-1:0] res_data;
  logic [1:0]    res_tag;
  logic [3:0]    busy_tags;
  logic          spurious_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  calc2_port_sequencer #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(8)) dut (
    .c_clk(c_clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
    .host_op1(host_op1), .host_op2(host_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .resp_in(resp_in), .data_in(data_in), .tag_in(tag_in),
    .res_valid(res_valid), .res_resp(res_resp), .res_data(res_data), .res_tag(res_tag),
    .busy_tags(busy_tags), .spurious_err(spurious_err)
  );

  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    host_valid = 1'b0; host_cmd = '0; host_op1 = '0; host_op2 = '0;
    resp_in = '0; data_in = '0; tag_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    cyc = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    host_valid = 1'b1; host_cmd = CMD_ADD;
    reset = 1'b1;
    tick(); tick(); #1;
    checks++;
    if ({host_ready, req_cmd_out, req_data_out, req_tag_out, res_valid, res_resp,
         res_data, res_tag, busy_tags, spurious_err} !== '0)
      begin errors++; $display("FAIL reset_outputs: got rdy=%b req=%h/%h/%h res=%b busy=%h spur=%b required all zero",
        host_ready, req_cmd_out, req_data_out, req_tag_out, res_valid, busy_tags, spurious_err); end
    host_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b required 1", host_ready); end
  endtask

  task automatic test_add();
    do_reset();
    host_valid = 1'b1; host_cmd = CMD_ADD; host_op1 = 5; host_op2 = 7;
    tick();
    idle_inputs();
    checks++;
    if ({req_cmd_out, req_data_out, req_tag_out} !== {4'd1, 32'd5, 2'd0})
      begin errors++; $display("FAIL add_issue: got %0d/%0d/%0d required 1/5/0", req_cmd_out, req_data_out, req_tag_out); end
    checks++;
    if ({busy_tags, host_ready} !== {4'b0001, 1'b0})
      begin errors++; $display("FAIL add_busy: got busy=%b rdy=%b required 0001/0", busy_tags, host_ready); end
    tick();
    checks++;
    if ({req_cmd_out, req_data_out, req_tag_out, host_ready} !== {4'd0, 32'd7, 2'd0, 1'b1})
      begin errors++; $display("FAIL add_op2: got %0d/%0d/%0d rdy=%b required 0/7/0 rdy=1", req_cmd_out, req_data_out, req_tag_out, host_ready); end
    resp_in = RESP_OK; data_in = 12; tag_in = 0;
    tick();
    idle_inputs();
    checks++;
    if ({res_valid, res_resp, res_data, res_tag} !== {1'b1, 2'b01, 32'd12, 2'd0})
      begin errors++; $display("FAIL add_result: got v=%b r=%b d=%0d t=%0d required 1/01/12/0", res_valid, res_resp, res_data, res_tag); end
    checks++;
    if ({busy_tags, req_cmd_out, req_data_out} !== '0)
      begin errors++; $display("FAIL add_free: got busy=%b req=%0d/%0d required 0", busy_tags, req_cmd_out, req_data_out); end
    tick();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL add_pulse: got res_valid=%b required 0", res_valid); end
  endtask

  task automatic test_exhaustion();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1; host_cmd = CMD_SUB; host_op1 = DW'(i);
      tick();
      idle_inputs();
      checks++;
      if ({req_cmd_out, req_tag_out} !== {4'd2, 2'(i)})
        begin errors++; $display("FAIL exh_tag%0d: got cmd=%0d tag=%0d required 2/%0d", i, req_cmd_out, req_tag_out, i); end
      tick();
    end
    checks++;
    if ({busy_tags, host_ready} !== {4'hF, 1'b0})
      begin errors++; $display("FAIL exh_full: got busy=%h rdy=%b required F/0", busy_tags, host_ready); end
    host_valid = 1'b1; host_cmd = CMD_SHL; host_op1 = 99;
    resp_in = RESP_OK; tag_in = 2; data_in = 55;
    tick();
    resp_in = '0; tag_in = '0; data_in = '0;
    checks++;
    if ({res_valid, res_resp, res_data, res_tag, busy_tags, req_cmd_out} !== {1'b1, 2'b01, 32'd55, 2'd2, 4'b1011, 4'd0})
      begin errors++; $display("FAIL exh_resp2: got v=%b d=%0d t=%0d busy=%b cmd=%0d required 1/55/2/1011/0",
        res_valid, res_data, res_tag, busy_tags, req_cmd_out); end
    tick();
    idle_inputs();
    checks++;
    if ({req_cmd_out, req_data_out, req_tag_out} !== {4'd5, 32'd99, 2'd2})
      begin errors++; $display("FAIL exh_realloc: got %0d/%0d/%0d required 5/99/2", req_cmd_out, req_data_out, req_tag_out); end
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    do_reset();
    host_valid = 1'b1; host_cmd = CMD_SHR; host_op1 = 1; host_op2 = 2;
    tick();
    idle_inputs();
    for (int k = 1; k < TO; k++) begin
      tick();
      if (res_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL to_early: got res_valid before cycle %0d required none", TO + 1); end
    tick();
    checks++;
    if ({res_valid, res_resp, res_data, res_tag, busy_tags} !== {1'b1, 2'b11, 32'd0, 2'd0, 4'd0})
      begin errors++; $display("FAIL to_result: got v=%b r=%b d=%0d t=%0d busy=%b required 1/11/0/0/0000 at cycle %0d",
        res_valid, res_resp, res_data, res_tag, busy_tags, cyc); end
    host_valid = 1'b1; host_cmd = CMD_ADD; host_op1 = 3;
    tick();
    idle_inputs();
    checks++;
    if ({req_tag_out, req_cmd_out, res_valid} !== {2'd0, 4'd1, 1'b0})
      begin errors++; $display("FAIL to_reuse: got tag=%0d cmd=%0d v=%b required 0/1/0", req_tag_out, req_cmd_out, res_valid); end
  endtask

  task automatic test_collision();
    do_reset();
    host_valid = 1'b1; host_cmd = CMD_ADD; host_op1 = 1;
    tick(); idle_inputs();
    tick();
    host_valid = 1'b1; host_cmd = CMD_SUB; host_op1 = 2;
    tick(); idle_inputs();
    checks++;
    if (req_tag_out !== 2'd1) begin errors++; $display("FAIL col_tag1: got %0d required 1", req_tag_out); end
    while (cyc < TO) tick();
    resp_in = RESP_ERR; tag_in = 1; data_in = 32'hAB;
    tick();
    idle_inputs();
    checks++;
    if ({res_valid, res_resp, res_data, res_tag} !== {1'b1, 2'b10, 32'hAB, 2'd1})
      begin errors++; $display("FAIL col_real: got v=%b r=%b d=%h t=%0d required 1/10/ab/1", res_valid, res_resp, res_data, res_tag); end
    tick();
    checks++;
    if ({res_valid, res_resp, res_data, res_tag, busy_tags} !== {1'b1, 2'b11, 32'd0, 2'd0, 4'd0})
      begin errors++; $display("FAIL col_timeout: got v=%b r=%b d=%h t=%0d busy=%b required 1/11/0/0/0000",
        res_valid, res_resp, res_data, res_tag, busy_tags); end
  endtask

  task automatic test_spurious();
    do_reset();
    resp_in = RESP_OK; tag_in = 3; data_in = 1;
    tick();
    idle_inputs();
    checks++;
    if ({res_valid, spurious_err} !== 2'b01)
      begin errors++; $display("FAIL spur_set: got v=%b spur=%b required 0/1", res_valid, spurious_err); end
    tick(); tick(); tick();
    checks++;
    if ({spurious_err, busy_tags} !== {1'b1, 4'd0})
      begin errors++; $display("FAIL spur_sticky: got spur=%b busy=%b required 1/0000", spurious_err, busy_tags); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (spurious_err !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b required 0", spurious_err); end
  endtask

  task automatic test_reset_op2();
    bit seen = 1'b0;
    do_reset();
    host_valid = 1'b1; host_cmd = CMD_ADD; host_op1 = 3; host_op2 = 4;
    tick();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if ({req_cmd_out, host_ready} !== {4'd1, 1'b0})
      begin errors++; $display("FAIL rop2_pre: got cmd=%0d rdy=%b required 1/0", req_cmd_out, host_ready); end
    tick();
    checks++;
    if ({req_cmd_out, req_data_out, req_tag_out, busy_tags, res_valid} !== '0)
      begin errors++; $display("FAIL rop2_clear: got req=%0d/%0d/%0d busy=%b v=%b required all 0",
        req_cmd_out, req_data_out, req_tag_out, busy_tags, res_valid); end
    reset = 1'b0;
    #1;
    checks++;
    if (host_ready !== 1'b1) begin errors++; $display("FAIL rop2_ready: got %b required 1", host_ready); end
    for (int k = 0; k < TO + 8; k++) begin
      tick();
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rop2_noresult: got a result for an abandoned op required none"); end
  endtask

  task automatic test_random(int n);
    logic [3:0]    cmds [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd9};
    bit            m_busy [4];
    int            m_issue [4];
    bit            m_op2, m_spur, m_ready, acc, picked, found;
    logic [DW-1:0] m_op2d;
    logic [3:0]    e_cmd;
    logic [DW-1:0] e_data, e_rd;
    logic [1:0]    e_tag, e_rr, e_rt;
    logic [3:0]    e_busy;
    bit            e_rv;
    int            free_t, alloc_t, st;
    do_reset();
    for (int t = 0; t < 4; t++) begin m_busy[t] = 1'b0; m_issue[t] = 0; end
    m_op2 = 1'b0; m_op2d = '0; m_spur = 1'b0;
    for (int c = 0; c < n; c++) begin
      host_valid = 1'($urandom_range(0, 1));
      host_cmd   = cmds[$urandom_range(0, 6)];
      host_op1   = $urandom;
      host_op2   = $urandom;
      resp_in = '0; tag_in = '0; data_in = '0;
      if ($urandom_range(0, 3) == 0) begin
        resp_in = 2'($urandom_range(1, 2));
        data_in = $urandom;
        tag_in  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) != 0) begin
          st = $urandom_range(0, 3);
          picked = 1'b0;
          for (int k = 0; k < 4; k++)
            if (!picked && m_busy[(st + k) % 4]) begin tag_in = 2'((st + k) % 4); picked = 1'b1; end
        end
      end
      #1;
      m_ready = !m_op2 && !(m_busy[0] && m_busy[1] && m_busy[2] && m_busy[3]);
      checks++;
      if (host_ready !== m_ready)
        begin errors++; $display("FAIL rnd_ready c=%0d: got %b required %b", c, host_ready, m_ready); end
      acc = host_valid && m_ready;
      e_rv = 1'b0; e_rr = '0; e_rd = '0; e_rt = '0; free_t = -1;
      if (resp_in != 2'd0) begin
        if (m_busy[tag_in]) begin
          e_rv = 1'b1; e_rr = resp_in; e_rd = data_in; e_rt = tag_in; free_t = int'(tag_in);
        end else begin
          m_spur = 1'b1;
        end
      end
      if (!e_rv) begin
        found = 1'b0;
        for (int t = 0; t < 4; t++)
          if (!found && m_busy[t] && (c + 1 >= m_issue[t] + TO)) begin
            found = 1'b1; e_rv = 1'b1; e_rr = 2'b11; e_rd = '0; e_rt = 2'(t); free_t = t;
          end
      end
      alloc_t = -1;
      for (int t = 3; t >= 0; t--) if (!m_busy[t]) alloc_t = t;
      if (free_t >= 0) m_busy[free_t] = 1'b0;
      e_cmd = '0; e_data = '0; e_tag = '0;
      if (acc && host_cmd != 4'd0) begin
        m_busy[alloc_t] = 1'b1;
        m_issue[alloc_t] = c + 1;
        e_cmd = host_cmd; e_data = host_op1; e_tag = 2'(alloc_t);
        m_op2 = 1'b1; m_op2d = host_op2;
      end else if (m_op2) begin
        e_data = m_op2d;
        m_op2 = 1'b0;
      end
      e_busy = {m_busy[3], m_busy[2], m_busy[1], m_busy[0]};
      tick();
      checks++;
      if ({req_cmd_out, req_data_out, req_tag_out} !== {e_cmd, e_data, e_tag})
        begin errors++; $display("FAIL rnd_req c=%0d: got %h/%h/%h required %h/%h/%h",
          c, req_cmd_out, req_data_out, req_tag_out, e_cmd, e_data, e_tag); end
      checks++;
      if (res_valid !== e_rv || (e_rv && {res_resp, res_data, res_tag} !== {e_rr, e_rd, e_rt}))
        begin errors++; $display("FAIL rnd_res c=%0d: got v=%b r=%b d=%h t=%0d required v=%b r=%b d=%h t=%0d",
          c, res_valid, res_resp, res_data, res_tag, e_rv, e_rr, e_rd, e_rt); end
      checks++;
      if ({busy_tags, spurious_err} !== {e_busy, m_spur})
        begin errors++; $display("FAIL rnd_busy c=%0d: got busy=%b spur=%b required busy=%b spur=%b",
          c, busy_tags, spurious_err, e_busy, m_spur); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_exhaustion();
    test_timeout();
    test_collision();
    test_spurious();
    test_reset_op2();
    test_random(800);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
